// File: rtl/muldiv_unit_pkg.sv
// Shared types for the RV32M multiply/divide unit: bus widths, op encoding and
// operand-signedness helpers.
package muldiv_unit_pkg;

   localparam int unsigned DATA_WIDTH    = 32;
   localparam int unsigned ADDRESS_WIDTH = 5;
   localparam int unsigned MD_STEPS      = DATA_WIDTH;

   typedef logic [DATA_WIDTH-1:0]    data_bus_t;
   typedef logic [ADDRESS_WIDTH-1:0] addr_bus_t;

   // Encoded as the RV32M funct3 field.
   typedef enum logic [2:0] {
      MdMul    = 3'd0,
      MdMulh   = 3'd1,
      MdMulhsu = 3'd2,
      MdMulhu  = 3'd3,
      MdDiv    = 3'd4,
      MdDivu   = 3'd5,
      MdRem    = 3'd6,
      MdRemu   = 3'd7
   } md_op_e;

   // MUL is treated as unsigned: the low word of the product is sign-agnostic.
   function automatic logic md_signed_a(md_op_e op);
      return op inside {MdMulh, MdMulhsu, MdDiv, MdRem};
   endfunction

   function automatic logic md_signed_b(md_op_e op);
      return op inside {MdMulh, MdDiv, MdRem};
   endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue/write-back bundle between the register-file stage and the mul/div unit.
interface muldiv_unit_if;
   import muldiv_unit_pkg::*;

   logic      start;
   md_op_e    op;
   data_bus_t rs1_val;
   data_bus_t rs2_val;
   addr_bus_t rd_in;
   logic      flush;
   logic      busy;
   logic      done;
   data_bus_t result;
   addr_bus_t rd_out;

   modport master (
      output start, op, rs1_val, rs2_val, rd_in, flush,
      input  busy, done, result, rd_out
   );

   modport slave (
      input  start, op, rs1_val, rs2_val, rd_in, flush,
      output busy, done, result, rd_out
   );

endinterface

// File: rtl/muldiv_unit_core.sv
// Shared iterative datapath: one 2*DATA_WIDTH accumulator used either as a
// shift-add multiplier or as a restoring divider, plus final sign fix-up.
module muldiv_unit_core
   import muldiv_unit_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      load,
   input  logic      step,
   input  md_op_e    op,
   input  logic      neg_a,
   input  logic      neg_b,
   input  data_bus_t a_mag,
   input  data_bus_t b_mag,
   output data_bus_t result
);

   localparam int unsigned DW = DATA_WIDTH;

   logic [2*DW-1:0] acc_q, acc_d, step_val, prod;
   data_bus_t       opb_q, opb_d;
   logic [DW:0]     mul_sum, div_trial;
   data_bus_t       quo, rem;

   // One iteration: multiply adds into the high half then shifts right;
   // divide shifts left and keeps the trial subtraction when it does not borrow.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      div_trial = acc_q[2*DW-1:DW-1] - {1'b0, opb_q};
      if (op[2]) begin
         if (!div_trial[DW]) begin
            step_val = {div_trial[DW-1:0], acc_q[DW-2:0], 1'b1};
         end else begin
            step_val = {acc_q[2*DW-2:0], 1'b0};
         end
      end else begin
         step_val = {mul_sum, acc_q[DW-1:1]};
      end
   end

   // Accumulator load/advance selection.
   always_comb begin
      acc_d = acc_q;
      opb_d = opb_q;
      if (load) begin
         acc_d = {{DW{1'b0}}, a_mag};
         opb_d = b_mag;
      end else if (step) begin
         acc_d = step_val;
      end
   end

   // Accumulator and operand-B storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         opb_q <= '0;
      end else begin
         acc_q <= acc_d;
         opb_q <= opb_d;
      end
   end

   // Sign fix-up of the post-step value; only meaningful on the final step.
   always_comb begin
      prod = (neg_a ^ neg_b) ? -step_val : step_val;
      quo  = (neg_a ^ neg_b) ? -step_val[DW-1:0] : step_val[DW-1:0];
      rem  = neg_a ? -step_val[2*DW-1:DW] : step_val[2*DW-1:DW];
      unique case (op)
         MdMul:                     result = prod[DW-1:0];
         MdMulh, MdMulhsu, MdMulhu: result = prod[2*DW-1:DW];
         MdDiv, MdDivu:             result = quo;
         default:                   result = rem;
      endcase
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: FSM, step counter, operand latches and
// divide special-case fast path around the shared datapath.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int unsigned STEPS = MD_STEPS
) (
   input logic           clk,
   input logic           rst_n,
   muldiv_unit_if.slave  bus
);

   localparam int unsigned CntW = $clog2(STEPS);
   localparam logic [CntW-1:0] LastCnt = CntW'(STEPS - 1);
   localparam data_bus_t MinNeg = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StCalc = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [CntW-1:0] count_q, count_d;
   md_op_e          op_q, op_d;
   addr_bus_t       rd_q, rd_d;
   data_bus_t       result_q, result_d;
   logic            neg_a_q, neg_a_d, neg_b_q, neg_b_d;

   logic      neg_a_in, neg_b_in, div_zero, div_ovf, special;
   data_bus_t a_mag, b_mag, special_res, core_result;
   logic      core_load, core_step;

   // Operand magnitudes and detection of results that need no iteration.
   always_comb begin
      neg_a_in = md_signed_a(bus.op) & bus.rs1_val[DATA_WIDTH-1];
      neg_b_in = md_signed_b(bus.op) & bus.rs2_val[DATA_WIDTH-1];
      a_mag    = neg_a_in ? -bus.rs1_val : bus.rs1_val;
      b_mag    = neg_b_in ? -bus.rs2_val : bus.rs2_val;
      div_zero = bus.op[2] && (bus.rs2_val == '0);
      div_ovf  = (bus.op inside {MdDiv, MdRem}) && (bus.rs1_val == MinNeg) &&
                 (bus.rs2_val == '1);
      special  = div_zero | div_ovf;
      // op[1] separates the remainder ops from the quotient ops.
      if (div_zero) begin
         special_res = bus.op[1] ? bus.rs1_val : '1;
      end else begin
         special_res = bus.op[1] ? '0 : MinNeg;
      end
   end

   // Next-state logic; flush overrides both issue and step progression.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      op_d      = op_q;
      rd_d      = rd_q;
      result_d  = result_q;
      neg_a_d   = neg_a_q;
      neg_b_d   = neg_b_q;
      core_load = 1'b0;
      core_step = 1'b0;
      if (bus.flush) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  op_d    = bus.op;
                  rd_d    = bus.rd_in;
                  neg_a_d = neg_a_in;
                  neg_b_d = neg_b_in;
                  count_d = '0;
                  if (special) begin
                     result_d = special_res;
                     state_d  = StDone;
                  end else begin
                     core_load = 1'b1;
                     state_d   = StCalc;
                  end
               end
            end
            StCalc: begin
               core_step = 1'b1;
               count_d   = count_q + 1'b1;
               if (count_q == LastCnt) begin
                  result_d = core_result;
                  state_d  = StDone;
               end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   // Control and latch registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         count_q  <= '0;
         op_q     <= MdMul;
         rd_q     <= '0;
         result_q <= '0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         op_q     <= op_d;
         rd_q     <= rd_d;
         result_q <= result_d;
         neg_a_q  <= neg_a_d;
         neg_b_q  <= neg_b_d;
      end
   end

   muldiv_unit_core u_core (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (core_load),
      .step   (core_step),
      .op     (op_q),
      .neg_a  (neg_a_q),
      .neg_b  (neg_b_q),
      .a_mag  (a_mag),
      .b_mag  (b_mag),
      .result (core_result)
   );

   // A flush arriving in DONE suppresses the write-back strobe.
   assign bus.busy   = (state_q != StIdle);
   assign bus.done   = (state_q == StDone) & ~bus.flush;
   assign bus.result = result_q;
   assign bus.rd_out = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with a result/rd scoreboard.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   muldiv_unit_if bus ();

   muldiv_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int vectors = 0;
   int miscompares = 0;
   data_bus_t exp_res_q[$];
   addr_bus_t exp_rd_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pop and compare when the DUT strobes done.
   task automatic score(input string tag);
      if (bus.done) begin
         if (exp_res_q.size() == 0) begin
            chk1({tag, " unexpected done"}, bus.done, 1'b0);
         end else begin
            chk({tag, " result"}, bus.result, exp_res_q.pop_front());
            chk({tag, " rd_out"}, {27'b0, bus.rd_out}, {27'b0, exp_rd_q.pop_front()});
         end
      end
   endtask

   task automatic drive(input md_op_e op, input data_bus_t a, input data_bus_t b,
                        input addr_bus_t rd);
      bus.op      = op;
      bus.rs1_val = a;
      bus.rs2_val = b;
      bus.rd_in   = rd;
   endtask

   // Issue in cycle 0, expect busy in 1..lat and done only in cycle lat.
   task automatic run_op(input string tag, input md_op_e op, input data_bus_t a,
                         input data_bus_t b, input addr_bus_t rd, input data_bus_t exp,
                         input int lat);
      exp_res_q.push_back(exp);
      exp_rd_q.push_back(rd);
      drive(op, a, b, rd);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int c = 1; c <= lat + 1; c++) begin
         chk1({tag, " busy"}, bus.busy, c <= lat);
         chk1({tag, " done"}, bus.done, c == lat);
         score(tag);
         if (c <= lat) tick();
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      drive(MdMul, '0, '0, '0);
      repeat (2) @(posedge clk);
      #1;
      chk1("reset busy", bus.busy, 1'b0);
      chk1("reset done", bus.done, 1'b0);
      chk("reset result", bus.result, 32'h0);
      chk("reset rd_out", {27'b0, bus.rd_out}, 32'h0);
      rst_n = 1'b1;
      tick();

      run_op("mul", MdMul, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33);
      run_op("mulhu", MdMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 33);
      run_op("mulh", MdMulh, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0000, 33);
      run_op("mulhsu", MdMulhsu, 32'hFFFF_FFFF, 32'd2, 5'd8, 32'hFFFF_FFFF, 33);
      run_op("div", MdDiv, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, 33);
      run_op("rem", MdRem, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, 33);
      run_op("divu rd0", MdDivu, 32'd100, 32'd7, 5'd0, 32'd14, 33);
      run_op("remu", MdRemu, 32'd100, 32'd7, 5'd11, 32'd2, 33);
      chk("hold result", bus.result, 32'd2);
      chk("hold rd_out", {27'b0, bus.rd_out}, 32'd11);

      run_op("divu by0", MdDivu, 32'h1234, 32'h0, 5'd12, 32'hFFFF_FFFF, 1);
      run_op("remu by0", MdRemu, 32'h1234, 32'h0, 5'd13, 32'h0000_1234, 1);
      run_op("div ovf", MdDiv, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1);
      run_op("rem ovf", MdRem, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h0, 1);

      // Back-to-back: start stays high through the first operation.
      exp_res_q.push_back(32'hFFFF_FFEB);
      exp_rd_q.push_back(5'd5);
      exp_res_q.push_back(32'd14);
      exp_rd_q.push_back(5'd3);
      drive(MdMul, 32'd7, 32'hFFFF_FFFD, 5'd5);
      bus.start = 1'b1;
      tick();
      drive(MdDivu, 32'd100, 32'd7, 5'd3);
      for (int c = 1; c <= 68; c++) begin
         chk1("b2b busy", bus.busy, (c <= 33) || (c >= 35 && c <= 67));
         chk1("b2b done", bus.done, (c == 33) || (c == 67));
         score("b2b");
         if (c == 35) bus.start = 1'b0;
         if (c < 68) tick();
      end

      // Flush in cycle 10 of a divide.
      drive(MdDivu, 32'd1000, 32'd3, 5'd4);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         chk1("flush busy", bus.busy, c <= 10);
         chk1("flush done", bus.done, 1'b0);
         if (c == 10) bus.flush = 1'b1;
         if (c == 11) bus.flush = 1'b0;
         tick();
      end
      chk("flush keeps result", bus.result, 32'd14);

      // Asynchronous reset in cycle 20 of a multiply.
      drive(MdMul, 32'd5, 32'd6, 5'd2);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         chk1("pre-reset busy", bus.busy, 1'b1);
         if (c < 20) tick();
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk1("async reset busy", bus.busy, 1'b0);
      chk1("async reset done", bus.done, 1'b0);
      chk("async reset result", bus.result, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < 40; c++) begin
         chk1("post-reset done", bus.done, 1'b0);
         tick();
      end
      run_op("mul after reset", MdMul, 32'd3, 32'd4, 5'd1, 32'd12, 33);

      chk("scoreboard drained", 32'(exp_res_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit. Sits directly downstream of the register file: it consumes the RD1/RD2 operands and the destination address, and produces a write-back result that drives the regfile AD3/WD3/WE3 ports. While a 32-step operation is in flight it raises busy so that control stalls fetch/decode. One operation is in flight at a time.

Parameters:
STEPS, DATA_WIDTH (32), number of iterations per operation, one result bit per cycle.

Ports:
clk  in  1  system clock; the only clock in the block.
rst_n  in  1  reset; asynchronous, active-low.
start  in  1  request; accepted only in IDLE.
op  in  3  MD_OP, encoded as funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
rs1_val  in  DATA_WIDTH  operand A (RD1).
rs2_val  in  DATA_WIDTH  operand B (RD2).
rd_in  in  ADDRESS_WIDTH  destination register.
flush  in  1  abort the current operation.
busy  out  1  high while the operation is in CALC or DONE.
done  out  1  one-cycle result strobe; also serves as regfile WE3.
result  out  DATA_WIDTH  write data (WD3); valid only while done=1.
rd_out  out  ADDRESS_WIDTH  latched destination (AD3); valid only while done=1.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: all flops clear asynchronously. State returns to IDLE, and busy, done, result and rd_out are all 0. Reset mid-operation discards the operation; done is never asserted for it.
- FSM states IDLE, CALC, DONE.
  - IDLE: if start=1 at an edge, latch op, the operands and rd_in, then go to CALC (count=0). Exception: a special case (see below) goes directly to DONE.
  - CALC: one step per cycle; count increments. After the step with count=STEPS-1, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Timing: start in cycle 0 gives busy=1 in cycles 1..33 and done=1 in cycle 33 only. The next start is accepted in cycle 34 (in IDLE). Special cases: busy=1 and done=1 in cycle 1 only.
- start while not in IDLE is ignored; no queueing. Upstream holds its instruction using busy.
- flush is valid in any state and has priority over start and step progression. The state goes to IDLE at the next edge, done stays 0, and no write-back occurs. flush and start together in IDLE: flush wins and the start is dropped.
- Multiply:
  - Convert signed operands to magnitudes and record the result sign. MULH treats both operands as signed; MULHSU treats only rs1 as signed; MUL/MULHU treat both as unsigned. MUL gives the same low word either way.
  - Run a shift-add algorithm over a 2*DATA_WIDTH product.
  - If the sign is negative, negate the 64-bit product in DONE.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- Divide:
  - Restoring divider over operand magnitudes, one quotient bit per cycle.
  - Signed quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
- Special cases (fast path, no CALC):
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- rd_in=0: the operation runs normally and done is still pulsed; the regfile's x0 write guard discards the result.
- result/rd_out hold their value after done drops. Consumers qualify them with done.

Decomposition:
- types_pkg gains the MD_OP enum (encodings above) and a localparam MD_STEPS = DATA_WIDTH. The unit uses the existing DATA_BUS/ADDR_BUS types.
- One natural sub-module is muldiv_core: a shared datapath with a 2*DATA_WIDTH accumulator, add/sub, shift and sign-fix logic. muldiv_unit keeps the FSM, counter, latches and special-case detection.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3), rd=5 -> done only in cycle 33, result=0xFFFFFFEB, rd_out=5, busy cycles 1..33.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> result=0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 0x1234/0 -> done in cycle 1, result=0xFFFFFFFF. REMU 0x1234/0 -> 0x1234. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in cycle 1. REM same operands -> 0.
- Back-to-back: second start held high during cycles 1..33 is ignored and accepted at cycle 34; its done lands in cycle 67. flush in cycle 10 -> busy=0 from cycle 11, no done pulse at all.
- rst_n low asynchronously in cycle 20 -> busy/done/result drop immediately. After release, no done appears; a fresh MUL 3×4 returns 12.
